switch_debounce2: RTL and testbench

//  Two-channel switch conditioner placed directly upstream of the 2-input AND gate.

---
 rtl/switch_debounce2.sv | 135 +++++++++++++
 tb/tb_switch_debounce2.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce2.sv
// -----------------------------------------------------------------------------
// switch_debounce2
//   Two-channel switch conditioner that sits directly in front of a 2-input
//   AND gate. Each raw switch level is brought into the clk domain through a
//   two-flop synchroniser and then debounced by a small STABLE/COUNT FSM. A new
//   level is accepted only after the synchronised input has disagreed with the
//   current output for STABLE_CNT consecutive edges. Any return to the old
//   level before that restarts qualification from zero.
//
//   Parameters
//     CNT_W       width of each per-channel stability counter
//     STABLE_CNT  consecutive cycles a new level must hold (2 .. 2**CNT_W-1)
//
//   Ports
//     clk     system clock, all logic on the rising edge
//     rst     synchronous, active-high reset
//     a_raw   asynchronous switch level, channel A
//     b_raw   asynchronous switch level, channel B
//     a_db    debounced level A (drives gate input a)
//     b_db    debounced level B (drives gate input b)
//     a_rise  one-cycle pulse in the first cycle a_db reads 1
//     b_rise  one-cycle pulse in the first cycle b_db reads 1
//     busy    high while either channel is counting toward a change
//
//   Latency for a clean step: 2 synchroniser edges + STABLE_CNT edges.
// -----------------------------------------------------------------------------
module switch_debounce2 #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic b_rise,
  output logic busy
);

  typedef enum logic {
    ST_STABLE,
    ST_COUNT
  } state_t;

  // Counter value on the edge that accepts the new level. The counter never
  // goes above this, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db;
  logic [1:0]       rise;
  logic [1:0]       next_count;
  state_t           state [2];
  logic [CNT_W-1:0] cnt   [2];

  assign raw = {b_raw, a_raw};

  // A channel will be in COUNT after this edge when its synchronised level
  // disagrees with the output and this edge is not the accepting one.
  // busy is the registered OR of that, so it changes on the same edge as the
  // FSM state rather than one cycle behind it.
  // NOTE: every always_comb output gets a default before any conditional
  // logic so that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_count = '0;
    for (int ch = 0; ch < 2; ch++) begin
      next_count[ch] = (sync2[ch] != db[ch]) &&
                       !((state[ch] == ST_COUNT) && (cnt[ch] == CNT_LAST));
    end
  end

  // NOTE: all state is assigned with non-blocking assignments so that every
  // register samples pre-edge values; sync2 <= sync1 therefore really builds
  // a two-stage pipeline instead of collapsing into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      rise  <= '0;
      busy  <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= ST_STABLE;
        cnt[ch]   <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      busy  <= |next_count;

      for (int ch = 0; ch < 2; ch++) begin
        rise[ch] <= 1'b0;
        case (state[ch])
          ST_STABLE: begin
            if (sync2[ch] != db[ch]) begin
              state[ch] <= ST_COUNT;
              cnt[ch]   <= CNT_W'(1);
            end
          end
          ST_COUNT: begin
            if (sync2[ch] == db[ch]) begin
              // Bounced back to the accepted level: discard the attempt.
              state[ch] <= ST_STABLE;
              cnt[ch]   <= '0;
            end else if (cnt[ch] == CNT_LAST) begin
              // Held for STABLE_CNT edges: accept. The strobe is raised only
              // for a 0->1 change, in the same cycle db first reads 1.
              db[ch]    <= sync2[ch];
              rise[ch]  <= sync2[ch];
              state[ch] <= ST_STABLE;
              cnt[ch]   <= '0;
            end else begin
              cnt[ch] <= cnt[ch] + CNT_W'(1);
            end
          end
          default: begin
            state[ch] <= ST_STABLE;
            cnt[ch]   <= '0;
          end
        endcase
      end
    end
  end

  assign a_db   = db[0];
  assign b_db   = db[1];
  assign a_rise = rise[0];
  assign b_rise = rise[1];

endmodule

// File: tb/tb_switch_debounce2.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce2
//   Self-checking bench for switch_debounce2 with STABLE_CNT = 4.
//   Every cycle is driven through step(): inputs are applied on the falling
//   edge, the expected outputs for the coming rising edge are computed by a
//   window-based reference model and pushed onto a scoreboard queue, and the
//   entry is popped and compared 1 time unit after the rising edge.
//   The reference model accepts a new level when the last STABLE_CNT
//   synchroniser outputs seen by the FSM all differ from the current output.
//   On top of that, hand-written sequences check exact edge positions, and a
//   table of segments checks hand-derived end states.
// -----------------------------------------------------------------------------
module tb_switch_debounce2;

  localparam int SC    = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst, a_raw, b_raw;
  logic a_db, b_db, a_rise, b_rise, busy;

  switch_debounce2 #(.CNT_W(CNT_W), .STABLE_CNT(SC)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a_db   (a_db),
    .b_db   (b_db),
    .a_rise (a_rise),
    .b_rise (b_rise),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic a_db;
    logic b_db;
    logic a_rise;
    logic b_rise;
    logic busy;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (index 0 = A, 1 = B).
  logic          m_s1   [2];
  logic          m_s2   [2];
  logic          m_db   [2];
  logic [SC-1:0] m_hist [2];
  int            m_hn   [2];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Computes the outputs expected after the next rising edge.
  task automatic model_edge(input logic r, input logic ra, input logic rb,
                            output exp_t e);
    logic raw [2];
    logic rs  [2];
    logic bs  [2];
    raw[0] = ra;
    raw[1] = rb;
    for (int ch = 0; ch < 2; ch++) begin
      rs[ch] = 1'b0;
      bs[ch] = 1'b0;
      if (r) begin
        m_s1[ch]   = 1'b0;
        m_s2[ch]   = 1'b0;
        m_db[ch]   = 1'b0;
        m_hist[ch] = '0;
        m_hn[ch]   = 0;
      end else begin
        logic seen;
        seen       = m_s2[ch];
        m_s2[ch]   = m_s1[ch];
        m_s1[ch]   = raw[ch];
        m_hist[ch] = {m_hist[ch][SC-2:0], seen};
        if (m_hn[ch] < SC) m_hn[ch]++;
        if (m_hn[ch] == SC && m_hist[ch] == {SC{~m_db[ch]}}) begin
          rs[ch]   = seen;
          m_db[ch] = seen;
        end
        bs[ch] = (seen != m_db[ch]);
      end
    end
    e.a_db   = m_db[0];
    e.b_db   = m_db[1];
    e.a_rise = rs[0];
    e.b_rise = rs[1];
    e.busy   = bs[0] | bs[1];
  endtask

  // One clock cycle: drive, predict, push; then pop and compare.
  task automatic step(input logic r, input logic ra, input logic rb);
    exp_t e;
    @(negedge clk);
    rst   = r;
    a_raw = ra;
    b_raw = rb;
    model_edge(r, ra, rb, e);
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    check("sb_a_db",   a_db,   e.a_db);
    check("sb_b_db",   b_db,   e.b_db);
    check("sb_a_rise", a_rise, e.a_rise);
    check("sb_b_rise", b_rise, e.b_rise);
    check("sb_busy",   busy,   e.busy);
  endtask

  typedef struct {
    logic r;
    logic ra;
    logic rb;
    int   ncyc;
    logic e_a_db;
    logic e_b_db;
    logic e_busy;
  } seg_t;

  seg_t segs [10];

  initial begin
    int rises;
    logic saw_busy, saw_rise;

    // Segment table: hold inputs for ncyc cycles, then expect these levels.
    segs[0] = '{0, 0, 0, 8, 0, 0, 0};
    segs[1] = '{0, 1, 0, 8, 1, 0, 0};
    segs[2] = '{0, 1, 1, 8, 1, 1, 0};
    segs[3] = '{0, 0, 1, 3, 1, 1, 1};  // A counting toward 0
    segs[4] = '{0, 0, 1, 5, 0, 1, 0};  // A accepted 0 after 6 edges total
    segs[5] = '{0, 0, 0, 8, 0, 0, 0};
    segs[6] = '{1, 1, 1, 2, 0, 0, 0};  // reset clears everything
    segs[7] = '{0, 1, 1, 5, 0, 0, 1};  // re-qualifying from zero
    segs[8] = '{0, 1, 1, 1, 1, 1, 0};  // sixth edge after release: accept
    segs[9] = '{0, 0, 0, 8, 0, 0, 0};

    rst   = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;

    // 1. Reset, then a clean rising step on A.
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("rst_a_db",   a_db,   1'b0);
    check("rst_b_db",   b_db,   1'b0);
    check("rst_a_rise", a_rise, 1'b0);
    check("rst_b_rise", b_rise, 1'b0);
    check("rst_busy",   busy,   1'b0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0);
    check("t1_a_db_edge5", a_db, 1'b0);
    step(0, 1, 0);
    check("t1_a_db_edge6",   a_db,   1'b1);
    check("t1_a_rise_edge6", a_rise, 1'b1);
    step(0, 1, 0);
    check("t1_a_rise_edge7", a_rise, 1'b0);
    check("t1_a_db_edge7",   a_db,   1'b1);

    // 4. Falling step on A: accepted after 6 edges, no strobe.
    saw_rise = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0);
      saw_rise |= a_rise;
    end
    check("t4_a_db_edge5", a_db, 1'b1);
    step(0, 0, 0);
    saw_rise |= a_rise;
    check("t4_a_db_edge6", a_db,     1'b0);
    check("t4_no_rise",    saw_rise, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // 2. Short pulse on A: busy pulses, output and strobe stay low.
    saw_busy = 1'b0;
    saw_rise = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      saw_busy |= busy;
      saw_rise |= a_rise;
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0);
      saw_busy |= busy;
      saw_rise |= a_rise;
    end
    check("t2_a_db",     a_db,     1'b0);
    check("t2_saw_busy", saw_busy, 1'b1);
    check("t2_no_rise",  saw_rise, 1'b0);
    check("t2_busy_end", busy,     1'b0);

    // 3. Bounce 1,0,1,0 then hold 1: one strobe, 6 edges after the final 0->1.
    rises = 0;
    step(0, 1, 0); rises += int'(a_rise);
    step(0, 0, 0); rises += int'(a_rise);
    step(0, 1, 0); rises += int'(a_rise);
    step(0, 0, 0); rises += int'(a_rise);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0);
      rises += int'(a_rise);
    end
    check("t3_a_db_edge5", a_db, 1'b0);
    step(0, 1, 0);
    rises += int'(a_rise);
    check("t3_a_db_edge6", a_db, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0);
      rises += int'(a_rise);
    end
    check("t3_one_rise", rises == 1, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 0, 0);

    // 5. Both channels step together: accept on the same edge.
    for (int i = 1; i <= 5; i++) step(0, 1, 1);
    check("t5_a_db_edge5", a_db, 1'b0);
    check("t5_b_db_edge5", b_db, 1'b0);
    step(0, 1, 1);
    check("t5_a_db",    a_db,        1'b1);
    check("t5_b_db",    b_db,        1'b1);
    check("t5_a_rise",  a_rise,      1'b1);
    check("t5_b_rise",  b_rise,      1'b1);
    check("t5_and_out", a_db & b_db, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 0, 0);

    // 6. Reset two cycles into a COUNT with A held high.
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    check("t6_busy_before_rst", busy, 1'b1);
    step(1, 1, 0);
    step(1, 1, 0);
    check("t6_rst_a_db", a_db, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0);
    check("t6_a_db_edge5", a_db, 1'b0);
    step(0, 1, 0);
    check("t6_a_db_edge6",   a_db,   1'b1);
    check("t6_a_rise_edge6", a_rise, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 0, 0);

    // Segment table.
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < segs[s].ncyc; c++) step(segs[s].r, segs[s].ra, segs[s].rb);
      check($sformatf("seg%0d_a_db", s), a_db, segs[s].e_a_db);
      check($sformatf("seg%0d_b_db", s), b_db, segs[s].e_b_db);
      check($sformatf("seg%0d_busy", s), busy, segs[s].e_busy);
    end

    // Random bouncy stimulus, checked cycle by cycle by the scoreboard.
    for (int n = 0; n < 120; n++) begin
      logic ra, rb, rr;
      int   hold;
      ra   = 1'($urandom_range(0, 1));
      rb   = 1'($urandom_range(0, 1));
      rr   = ($urandom_range(0, 39) == 0);
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) step(rr, ra, rb);
    end

    check("queue_drained", q_exp.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
